// File: rtl/wptr_ctrl.sv
// wptr_ctrl: write-side pointer, full/almost-full and fill-level logic of an async FIFO.
// Optional sticky overflow flag, enabled by defining WPTR_CTRL_OVERFLOW_EN.
module wptr_ctrl #(
    parameter int PTR_WIDTH = 4,
    parameter int AF_MARGIN = 2
) (
    input  logic               wclk,
    input  logic               wrst_n,
    input  logic               w_en,
    input  logic [PTR_WIDTH:0] g_rptr_sync,
    input  logic               ovf_clr,
    output logic [PTR_WIDTH:0] b_wptr,
    output logic [PTR_WIDTH:0] g_wptr,
    output logic               full,
    output logic               almost_full,
    output logic [PTR_WIDTH:0] wr_count,
    output logic               overflow
);

    localparam int W     = PTR_WIDTH + 1;
    localparam int DEPTH = 1 << PTR_WIDTH;

    localparam logic [W-1:0] AF_LVL = W'(DEPTH - AF_MARGIN);

    logic         wr_acc;
    logic [W-1:0] b_next;
    logic [W-1:0] g_next;
    logic [W-1:0] rbin;
    logic [W-1:0] fill_next;
    logic [W-1:0] full_cmp;

    // Next pointers, read pointer decode and flag terms
    always_comb begin
        wr_acc    = w_en & ~full;
        b_next    = b_wptr + {{PTR_WIDTH{1'b0}}, wr_acc};
        g_next    = (b_next >> 1) ^ b_next;
        for (int i = 0; i < W; i++) begin
            rbin[i] = ^(g_rptr_sync >> i);
        end
        fill_next = b_next - rbin;
        full_cmp  = {~g_rptr_sync[PTR_WIDTH:PTR_WIDTH-1],
                     g_rptr_sync[PTR_WIDTH-2:0]};
    end

    // Pointer, fill level and flag registers
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            b_wptr      <= '0;
            g_wptr      <= '0;
            wr_count    <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
        end else begin
            b_wptr      <= b_next;
            g_wptr      <= g_next;
            wr_count    <= fill_next;
            full        <= (g_next == full_cmp);
            almost_full <= (fill_next >= AF_LVL);
        end
    end

`ifdef WPTR_CTRL_OVERFLOW_EN
    // Sticky overflow: a dropped write sets it, set beats clear
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            overflow <= 1'b0;
        end else if (w_en & full) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end
`else
    logic unused_ovf_clr;

    assign unused_ovf_clr = ovf_clr;
    assign overflow       = 1'b0;
`endif

endmodule

// File: doc/wptr_ctrl.md
WPTR_CTRL -- requirements
Module: wptr_ctrl

Interface
REQ-001 The block SHALL have parameter PTR_WIDTH, default 4, setting FIFO depth DEPTH = 2^PTR_WIDTH and pointer width PTR_WIDTH+1.
REQ-002 The block SHALL have parameter AF_MARGIN, default 2, setting the free-slot count at or below which almost_full asserts.
REQ-003 wclk  input  1  write-domain clock; all state updates on rising edge.
REQ-004 wrst_n  input  1  asynchronous active-low reset.
REQ-005 w_en  input  1  write request from the producer.
REQ-006 g_rptr_sync  input  PTR_WIDTH+1  Gray read pointer, already synchronised into wclk.
REQ-007 ovf_clr  input  1  clears the sticky overflow flag.
REQ-008 b_wptr  output  PTR_WIDTH+1  registered binary write pointer; low PTR_WIDTH bits address the memory.
REQ-009 g_wptr  output  PTR_WIDTH+1  registered Gray write pointer, sent to the read-domain synchroniser.
REQ-010 full  output  1  registered full flag.
REQ-011 almost_full  output  1  registered almost-full flag.
REQ-012 wr_count  output  PTR_WIDTH+1  registered fill level, range 0..DEPTH.
REQ-013 overflow  output  1  sticky flag: write attempted while full.

Function
REQ-014 Accepted write SHALL be w_en & !full; b_wptr_next = b_wptr + accepted, modulo 2^(PTR_WIDTH+1).
REQ-015 g_wptr_next SHALL be (b_wptr_next >> 1) ^ b_wptr_next; b_wptr and g_wptr SHALL both load their next values every wclk edge.
REQ-016 The synchronised read pointer SHALL be converted Gray-to-binary combinationally (rbin[i] = XOR of g_rptr_sync[PTR_WIDTH:i]).
REQ-017 full SHALL load (g_wptr_next == {~g_rptr_sync[PTR_WIDTH:PTR_WIDTH-1], g_rptr_sync[PTR_WIDTH-2:0]}) each edge.
REQ-018 wr_count SHALL load (b_wptr_next - rbin) modulo 2^(PTR_WIDTH+1) each edge.
REQ-019 almost_full SHALL load (b_wptr_next - rbin) >= DEPTH - AF_MARGIN each edge; full implies almost_full.
REQ-020 Flags SHALL be pessimistic: a read pointer advance lowers full/wr_count only on the first edge after g_rptr_sync changes; writes take effect on the same edge.
REQ-021 A w_en while full SHALL be dropped; pointers and wr_count SHALL hold.
REQ-022 Pointer wrap SHALL be seamless: b_wptr 5'h1F -> 5'h00, g_wptr 5'h10 -> 5'h00 (PTR_WIDTH=4), with exactly one Gray bit changing per increment.
REQ-023 g_wptr SHALL be driven directly from a register; no combinational logic between flop and port.

Reset
REQ-024 On wrst_n low, b_wptr, g_wptr, wr_count SHALL go to 0, full and almost_full to 0, overflow to 0, asynchronously.
REQ-025 Reset mid-operation SHALL discard pointer state; the first write after release SHALL produce b_wptr=1, g_wptr=1.
REQ-026 Deassertion SHALL take effect at the next wclk edge; no write is accepted in the cycle wrst_n rises if sampled low.

Configuration
REQ-027 Macro WPTR_CTRL_OVERFLOW_EN defined: overflow SHALL set on any edge where w_en & full, clear on ovf_clr, set winning over clear in the same cycle.
REQ-028 Macro WPTR_CTRL_OVERFLOW_EN undefined: overflow SHALL be tied 0, ovf_clr ignored, no overflow flop synthesised.

Verification (PTR_WIDTH=4, AF_MARGIN=2)
REQ-029 Reset asserted with w_en=1 -> b_wptr=0, g_wptr=0, full=0, almost_full=0, wr_count=0, overflow=0.
REQ-030 g_rptr_sync=0, 16 consecutive writes -> almost_full=1 after 14th edge; after 16th edge b_wptr=5'h10, g_wptr=5'h18, wr_count=16, full=1.
REQ-031 From full, w_en=1 one cycle -> pointers unchanged, overflow=1 (macro defined) or 0 (undefined); ovf_clr=1 -> overflow=0 next edge.
REQ-032 From full, g_rptr_sync set to 5'h06 (binary 4) -> next edge full=0, almost_full=0, wr_count=12.
REQ-033 Continuous write/read-pointer chase over 40 writes -> b_wptr passes 5'h1F -> 5'h00, g_wptr 5'h10 -> 5'h00, single-bit Gray changes throughout, wr_count never exceeds 16.
REQ-034 wrst_n pulsed low with wr_count=9 -> all outputs 0 immediately; next accepted write gives b_wptr=1, wr_count=1.
